// File: rtl/draw_waveform_triggered.sv
// draw_waveform_triggered: captures mic samples in a circular buffer, freezes a trace around a trigger and draws it as a connected line.
// Latency: VGA coordinates to registered colour in 2 cycles. Samples are captured on the cycle sample_en is high.
// Backpressure: none. sample_en and frame_start are strobes, and samples that arrive in HOLD are dropped by design.
// Ports: CLK/RESET (synchronous, active-high); sample_en/wave_sample (sample input);
//        trig_mode/trig_edge/trig_level (trigger setup); freeze/frame_start (hold control);
//        trace_colour plus VGA_HORZ/VERT_COORD in; VGA_*_waveform colour out; trig_state/triggered status out.
module draw_waveform_triggered #(
  parameter int SAMPLE_W     = 10,
  parameter int DEPTH        = 1280,
  parameter int COORD_W      = 12,
  parameter int Y_BASE       = 1024,
  parameter int PRE_TRIG     = 320,
  parameter int HOLD_FRAMES  = 30,
  parameter int AUTO_TIMEOUT = 20000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] wave_sample,
  input  logic [1:0]          trig_mode,
  input  logic                trig_edge,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                freeze,
  input  logic                frame_start,
  input  logic [11:0]         trace_colour,
  input  logic [COORD_W-1:0]  VGA_HORZ_COORD,
  input  logic [COORD_W-1:0]  VGA_VERT_COORD,
  output logic [3:0]          VGA_Red_waveform,
  output logic [3:0]          VGA_Green_waveform,
  output logic [3:0]          VGA_Blue_waveform,
  output logic [2:0]          trig_state,
  output logic                triggered
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(AUTO_TIMEOUT + DEPTH + 1);
  localparam int FCNT_W = $clog2(HOLD_FRAMES + 2);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]   PRE_P     = PTR_W'(PRE_TRIG);
  localparam logic [PTR_W-1:0]   WRAP_ADJ  = PTR_W'(DEPTH - PRE_TRIG);
  localparam logic [CNT_W-1:0]   PRE_LAST  = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]   POST_LAST = CNT_W'(POST_N - 1);
  localparam logic [CNT_W-1:0]   AUTO_LAST = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [FCNT_W-1:0]  HOLD_F    = FCNT_W'(HOLD_FRAMES);
  localparam logic [COORD_W:0]   DEPTH_C   = (COORD_W+1)'(DEPTH);
  localparam logic [COORD_W:0]   Y_BASE_C  = (COORD_W+1)'(Y_BASE);

  typedef enum logic [2:0] {
    ST_FREE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, wr_next, disp_base, trig_ptr, trig_base;
  logic [CNT_W-1:0]    cnt;
  logic [FCNT_W-1:0]   fcnt;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                wr_en, trig_evt, fill_done, post_done;

  // With no post-trigger samples, the POST cycle must not overwrite the oldest pre-trigger sample.
  assign wr_en = sample_en && (state != ST_HOLD) && !((state == ST_POST) && (POST_N == 0));
  assign wr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
  assign trig_evt = trig_edge ? ((prev_sample >= trig_level) && (wave_sample < trig_level))
                              : ((prev_sample < trig_level) && (wave_sample >= trig_level));
  assign fill_done = (state == ST_FILL) && ((PRE_TRIG == 0) || (sample_en && (cnt == PRE_LAST)));
  assign post_done = (state == ST_POST) && ((POST_N == 0) || (sample_en && (cnt == POST_LAST)));
  // Oldest sample of the frozen trace: (trig_ptr - PRE_TRIG) mod DEPTH.
  assign trig_base = (trig_ptr >= PRE_P) ? trig_ptr - PRE_P : trig_ptr + WRAP_ADJ;
  assign trig_state = state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_FILL;
      wr_ptr      <= '0;
      disp_base   <= '0;
      trig_ptr    <= '0;
      cnt         <= '0;
      fcnt        <= '0;
      prev_sample <= '0;
      triggered   <= 1'b0;
    end else begin
      if (sample_en) prev_sample <= wave_sample;
      if (wr_en) wr_ptr <= wr_next;
      if (trig_mode == 2'd0) begin
        // Free-run overrides everything. The display follows the write pointer, so the oldest sample lands at x=0.
        state     <= ST_FREE;
        triggered <= 1'b0;
        cnt       <= '0;
        fcnt      <= '0;
        if (wr_en) disp_base <= wr_next;
      end else begin
        case (state)
          ST_FREE: begin
            state <= ST_FILL;
            cnt   <= '0;
          end
          ST_FILL: begin
            if (fill_done) begin
              state <= ST_ARMED;
              cnt   <= '0;
            end else if (sample_en) begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_ARMED: begin
            if (sample_en) begin
              if (trig_evt || ((trig_mode == 2'd2) && (cnt == AUTO_LAST))) begin
                trig_ptr <= wr_ptr;
                cnt      <= '0;
                state    <= ST_POST;
              end else if (cnt != AUTO_LAST) begin
                // Saturate so that a later switch to auto mode forces a trigger promptly.
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_POST: begin
            if (post_done) begin
              disp_base <= trig_base;
              triggered <= 1'b1;
              fcnt      <= '0;
              cnt       <= '0;
              state     <= ST_HOLD;
            end else if (sample_en) begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HOLD: begin
            if (!freeze) begin
              if (fcnt >= HOLD_F) begin
                triggered <= 1'b0;
                fcnt      <= '0;
                cnt       <= '0;
                state     <= ST_FILL;
              end else if (frame_start) begin
                fcnt <= fcnt + 1'b1;
              end
            end
          end
          default: state <= ST_FILL;
        endcase
      end
    end
  end

  // Display stage 1: buffer read at (disp_base + x) mod DEPTH.
  logic [COORD_W:0]    addr_sum;
  logic [PTR_W-1:0]    rd_addr;
  logic                x_in_range;
  logic [SAMPLE_W-1:0] rd_dat;

  assign x_in_range = ((COORD_W+1)'(VGA_HORZ_COORD) < DEPTH_C);
  assign addr_sum   = (COORD_W+1)'(disp_base) + (COORD_W+1)'(VGA_HORZ_COORD);
  assign rd_addr    = (addr_sum >= DEPTH_C) ? PTR_W'(addr_sum - DEPTH_C) : PTR_W'(addr_sum);

  // The buffer is deliberately never cleared, so it stays RAM-inferable.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wave_sample;
    if (x_in_range) rd_dat <= mem[rd_addr];
  end

  logic               vld_s1;
  logic [COORD_W-1:0] x_s1, y_s1, last_x;
  logic [SAMPLE_W-1:0] last_dat, prev_col, prev_eff;
  logic [COORD_W:0]   ya, yb, y_lo, y_hi;
  logic               lit;

  // Display stage 2: when x changes, the sample read last cycle belongs to the previous column.
  assign prev_eff = (x_s1 != last_x) ? last_dat : prev_col;
  assign ya   = Y_BASE_C - (COORD_W+1)'(rd_dat);
  assign yb   = (x_s1 == '0) ? ya : Y_BASE_C - (COORD_W+1)'(prev_eff);
  assign y_lo = (ya < yb) ? ya : yb;
  assign y_hi = (ya < yb) ? yb : ya;
  assign lit  = vld_s1 && ({1'b0, y_s1} >= y_lo) && ({1'b0, y_s1} <= y_hi);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_s1             <= 1'b0;
      x_s1               <= '0;
      y_s1               <= '0;
      last_x             <= '0;
      last_dat           <= '0;
      prev_col           <= '0;
      VGA_Red_waveform   <= '0;
      VGA_Green_waveform <= '0;
      VGA_Blue_waveform  <= '0;
    end else begin
      vld_s1             <= x_in_range;
      x_s1               <= VGA_HORZ_COORD;
      y_s1               <= VGA_VERT_COORD;
      last_x             <= x_s1;
      last_dat           <= rd_dat;
      prev_col           <= prev_eff;
      VGA_Red_waveform   <= lit ? trace_colour[11:8] : 4'h0;
      VGA_Green_waveform <= lit ? trace_colour[7:4]  : 4'h0;
      VGA_Blue_waveform  <= lit ? trace_colour[3:0]  : 4'h0;
    end
  end

endmodule

// File: tb/tb_draw_waveform_triggered.sv
module tb_draw_waveform_triggered;
  localparam int SAMPLE_W     = 10;
  localparam int DEPTH        = 1280;
  localparam int COORD_W      = 12;
  localparam int Y_BASE       = 1024;
  localparam int PRE_TRIG     = 320;
  localparam int HOLD_FRAMES  = 30;
  localparam int AUTO_TIMEOUT = 20000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                RESET = 1'b1;
  logic                sample_en = 1'b0;
  logic [SAMPLE_W-1:0] wave_sample = '0;
  logic [1:0]          trig_mode = 2'd1;
  logic                trig_edge = 1'b0;
  logic [SAMPLE_W-1:0] trig_level = 10'd512;
  logic                freeze = 1'b0;
  logic                frame_start = 1'b0;
  logic [11:0]         trace_colour = 12'hABC;
  logic [COORD_W-1:0]  VGA_HORZ_COORD = '0;
  logic [COORD_W-1:0]  VGA_VERT_COORD = '0;
  logic [3:0]          VGA_Red_waveform, VGA_Green_waveform, VGA_Blue_waveform;
  logic [2:0]          trig_state;
  logic                triggered;

  draw_waveform_triggered #(
    .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .COORD_W(COORD_W), .Y_BASE(Y_BASE),
    .PRE_TRIG(PRE_TRIG), .HOLD_FRAMES(HOLD_FRAMES), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .sample_en(sample_en), .wave_sample(wave_sample),
    .trig_mode(trig_mode), .trig_edge(trig_edge), .trig_level(trig_level),
    .freeze(freeze), .frame_start(frame_start), .trace_colour(trace_colour),
    .VGA_HORZ_COORD(VGA_HORZ_COORD), .VGA_VERT_COORD(VGA_VERT_COORD),
    .VGA_Red_waveform(VGA_Red_waveform), .VGA_Green_waveform(VGA_Green_waveform),
    .VGA_Blue_waveform(VGA_Blue_waveform), .trig_state(trig_state), .triggered(triggered)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int trace [DEPTH];
  logic [11:0] exp_q [$];
  string       tag_q [$];
  logic drv_vld = 1'b0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int colour_out();
    return int'({VGA_Red_waveform, VGA_Green_waveform, VGA_Blue_waveform});
  endfunction

  // One clock. Probes travel a 2-stage tag pipeline and are scored when their colour appears.
  task automatic tick();
    logic [11:0] e;
    string t;
    @(posedge CLK);
    #1;
    s2 = s1;
    s1 = drv_vld;
    drv_vld = 1'b0;
    if (s2 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, colour_out(), int'(e));
    end
  endtask

  function automatic logic [11:0] model_px(input int x, input int y);
    int ya, yb, lo, hi;
    if (x >= DEPTH) return 12'h000;
    ya = Y_BASE - trace[x];
    yb = (x == 0) ? ya : Y_BASE - trace[x-1];
    lo = (ya < yb) ? ya : yb;
    hi = (ya < yb) ? yb : ya;
    return (y >= lo && y <= hi) ? trace_colour : 12'h000;
  endfunction

  task automatic probe_exp(input int x, input int y, input logic [11:0] e, input string name);
    VGA_HORZ_COORD = COORD_W'(x);
    VGA_VERT_COORD = COORD_W'(y);
    drv_vld = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back($sformatf("%s x=%0d y=%0d", name, x, y));
    tick();
  endtask

  task automatic scan(input int y, input int xmax, input string name);
    for (int x = 0; x <= xmax; x++) probe_exp(x, y, model_px(x, y), name);
    tick();
    tick();
  endtask

  task automatic feed(input int v);
    sample_en = 1'b1;
    wave_sample = SAMPLE_W'(v);
    tick();
    sample_en = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  function automatic int samp(input int i);
    int v;
    v = i % 256;
    return (v < 128) ? 200 + v * 5 : 200 + (255 - v) * 5;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int trig_idx;
    int post_n;
    post_n = DEPTH - PRE_TRIG - 1;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset state
    check("rst_state", int'(trig_state), 1);
    check("rst_triggered", int'(triggered), 0);
    check("rst_colour", colour_out(), 0);

    // T1: free-run ramp
    trace_colour = 12'hABC;
    trig_mode = 2'd0;
    tick();
    check("T1_state_free", int'(trig_state), 0);
    for (int i = 0; i < DEPTH; i++) begin
      trace[i] = i % 1024;
      feed(trace[i]);
    end
    check("T1_triggered", int'(triggered), 0);
    scan(Y_BASE - 100, DEPTH + 2, "T1");
    scan(Y_BASE - 1000, DEPTH + 2, "T1");
    scan(Y_BASE, DEPTH + 2, "T1");

    // T4: connected line between samples 100 and 400
    trace_colour = 12'h5F3;
    for (int i = 0; i < DEPTH; i++) begin
      trace[i] = (i == 10) ? 100 : (i == 11) ? 400 : 500;
      feed(trace[i]);
    end
    scan(Y_BASE - 401, 20, "T4");
    scan(Y_BASE - 400, 20, "T4");
    scan(Y_BASE - 250, 20, "T4");
    scan(Y_BASE - 100, 20, "T4");
    scan(Y_BASE - 99, 20, "T4");

    // T2: rising trigger at 512 on a triangle wave
    trig_mode = 2'd1;
    trig_edge = 1'b0;
    trig_level = 10'd512;
    trace_colour = 12'hF0F;
    do_reset();
    trig_idx = PRE_TRIG;
    for (int i = 1700; i >= PRE_TRIG; i--)
      if (samp(i - 1) < 512 && samp(i) >= 512) trig_idx = i;
    for (int i = 0; i < 1700; i++) begin
      feed(samp(i));
      if (i == trig_idx - 1)      check("T2_armed", int'(trig_state), 2);
      if (i == trig_idx)          check("T2_post", int'(trig_state), 3);
      if (i == trig_idx + post_n - 1) check("T2_post_end", int'(trig_state), 3);
      if (i == trig_idx + post_n) check("T2_hold", int'(trig_state), 4);
    end
    check("T2_triggered", int'(triggered), 1);
    for (int x = 0; x < DEPTH; x++) trace[x] = samp(trig_idx - PRE_TRIG + x);
    scan(Y_BASE - 520, DEPTH + 2, "T2");
    scan(Y_BASE - 512, DEPTH + 2, "T2");
    scan(Y_BASE - 200, DEPTH + 2, "T2");

    // T5: hold timing with freeze
    repeat (HOLD_FRAMES - 1) pulse_frame();
    check("T5_hold_29", int'(trig_state), 4);
    freeze = 1'b1;
    repeat (5) pulse_frame();
    check("T5_frozen", int'(trig_state), 4);
    check("T5_frozen_trig", int'(triggered), 1);
    freeze = 1'b0;
    tick();
    check("T5_released", int'(trig_state), 4);
    pulse_frame();
    check("T5_refill", int'(trig_state), 1);
    check("T5_untrig", int'(triggered), 0);

    // T3: falling edge on a constant input: normal mode never fires, auto mode forces it
    trig_mode = 2'd1;
    trig_edge = 1'b1;
    do_reset();
    repeat (20500) feed(100);
    check("T3_normal_armed", int'(trig_state), 2);
    check("T3_normal_trig", int'(triggered), 0);
    trig_mode = 2'd2;
    do_reset();
    for (int i = 0; i <= PRE_TRIG + AUTO_TIMEOUT - 1 + post_n; i++) begin
      feed(100);
      if (i == PRE_TRIG + AUTO_TIMEOUT - 2) check("T3_auto_armed", int'(trig_state), 2);
      if (i == PRE_TRIG + AUTO_TIMEOUT - 1) check("T3_auto_fire", int'(trig_state), 3);
      if (i == PRE_TRIG + AUTO_TIMEOUT - 2 + post_n) check("T3_auto_post", int'(trig_state), 3);
    end
    check("T3_auto_hold", int'(trig_state), 4);
    check("T3_auto_trig", int'(triggered), 1);

    // T6: reset in POST
    trig_mode = 2'd1;
    trig_edge = 1'b0;
    do_reset();
    repeat (PRE_TRIG) feed(100);
    feed(600);
    check("T6_post", int'(trig_state), 3);
    repeat (5) feed(100);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("T6_rst_state", int'(trig_state), 1);
    check("T6_rst_trig", int'(triggered), 0);
    check("T6_rst_colour", colour_out(), 0);
    // A reset write pointer puts the next free-run sample at address 0, which is shown at x=DEPTH-1.
    trace_colour = 12'h3C5;
    trig_mode = 2'd0;
    tick();
    feed(777);
    VGA_HORZ_COORD = COORD_W'(DEPTH - 2);
    VGA_VERT_COORD = COORD_W'(Y_BASE - 777);
    tick();
    probe_exp(DEPTH - 1, Y_BASE - 777, trace_colour, "T6_wrptr");
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
